// File: rtl/vending_pkg.sv
// vending_pkg: shared types, prices, limits and coin decode for the vending controller
package vending_pkg;
  localparam int NUM_PRODUCTS = 4;
  localparam int CREDIT_W = 8;
  localparam logic [CREDIT_W-1:0] MAX_CREDIT = 8'd40;
  localparam logic [3:0] STOCK_INIT = 4'd3;
  localparam logic [NUM_PRODUCTS-1:0][CREDIT_W-1:0] PRICE = {8'd30, 8'd25, 8'd15, 8'd10};
  typedef enum logic [1:0] {IDLE, COLLECT, VEND, CHANGE} state_t;
  typedef enum logic [1:0] {COIN_5C, COIN_10C, COIN_25C, COIN_100C} coin_t;
  function automatic logic [CREDIT_W-1:0] coin_units(coin_t c);
    return c == COIN_5C ? 8'd1 : c == COIN_10C ? 8'd2 : c == COIN_25C ? 8'd5 : 8'd20;
  endfunction
endpackage

// File: rtl/vending_if.sv
// vending_if: front-end strobes and actuator outputs shared by the controller and its driver
interface vending_if;
  import vending_pkg::*;
  logic coin_valid;
  coin_t coin_type;
  logic sel_valid;
  logic [1:0] sel_id;
  logic cancel;
  logic [CREDIT_W-1:0] credit;
  logic coin_reject;
  logic dispense_valid;
  logic [1:0] dispense_id;
  logic change_valid;
  logic [CREDIT_W-1:0] change_amount;
  logic sel_error;
  logic busy;
  logic [NUM_PRODUCTS-1:0] sold_out;
  modport master(output coin_valid, coin_type, sel_valid, sel_id, cancel,
                 input credit, coin_reject, dispense_valid, dispense_id, change_valid,
                 change_amount, sel_error, busy, sold_out);
  modport slave(input coin_valid, coin_type, sel_valid, sel_id, cancel,
                output credit, coin_reject, dispense_valid, dispense_id, change_valid,
                change_amount, sel_error, busy, sold_out);
endinterface

// File: rtl/vending_coin_value.sv
// vending_coin_value: combinational decode of a coin type into 5-cent credit units
module vending_coin_value
  import vending_pkg::*;
(
  input  coin_t coin_type,
  output logic [CREDIT_W-1:0] value
);
  assign value = coin_units(coin_type);
endmodule

// File: rtl/vending_machine.sv
// vending_machine: credit/vend/change controller with registered outputs.
// Define VENDING_STOCK_EN to enable per-product stock counters and sold_out.
module vending_machine
  import vending_pkg::*;
(
  input logic clk,
  input logic rst,
  vending_if.slave bus
);
  state_t state, state_d;
  logic [CREDIT_W-1:0] value, sum, pending, pending_d, credit_d, price_sel;
  logic open, cancel_go, sel_go, sel_ok, coin_go, in_stock;
  vending_coin_value u_coin (.coin_type(bus.coin_type), .value(value));
  assign price_sel = PRICE[bus.sel_id];
  assign sum = bus.credit + value;
  assign open = state == IDLE || state == COLLECT;
  assign cancel_go = bus.cancel && state == COLLECT;
  assign sel_go = open && bus.sel_valid && !cancel_go;
  assign sel_ok = sel_go && bus.credit >= price_sel && in_stock;
  // any accepted cancel or selection in the same cycle bounces the coin
  assign coin_go = open && bus.coin_valid && !cancel_go && !bus.sel_valid && sum <= MAX_CREDIT;
  always_comb begin
    state_d = state;
    credit_d = bus.credit;
    pending_d = pending;
    if (!open) begin
      state_d = state == VEND && pending != '0 ? CHANGE : IDLE;
    end else if (cancel_go) begin
      state_d = CHANGE;
      pending_d = bus.credit;
      credit_d = '0;
    end else if (sel_ok) begin
      state_d = VEND;
      pending_d = bus.credit - price_sel;
      credit_d = '0;
    end else if (coin_go) begin
      state_d = COLLECT;
      credit_d = sum;
    end
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      state <= IDLE;
      pending <= '0;
      bus.credit <= '0;
      bus.coin_reject <= 1'b0;
      bus.dispense_valid <= 1'b0;
      bus.dispense_id <= '0;
      bus.change_valid <= 1'b0;
      bus.change_amount <= '0;
      bus.sel_error <= 1'b0;
      bus.busy <= 1'b0;
    end else begin
      state <= state_d;
      pending <= pending_d;
      bus.credit <= credit_d;
      bus.coin_reject <= bus.coin_valid && !coin_go;
      bus.dispense_valid <= sel_ok;
      bus.dispense_id <= sel_ok ? bus.sel_id : 2'd0;
      bus.change_valid <= state_d == CHANGE;
      bus.change_amount <= state_d == CHANGE ? pending_d : '0;
      bus.sel_error <= sel_go && !sel_ok;
      bus.busy <= state_d == VEND || state_d == CHANGE;
    end
  end
`ifdef VENDING_STOCK_EN
  logic [3:0] stock [NUM_PRODUCTS];
  assign in_stock = stock[bus.sel_id] != 4'd0;
  always_ff @(posedge clk) begin
    for (int k = 0; k < NUM_PRODUCTS; k++)
      stock[k] <= rst ? STOCK_INIT : stock[k] - 4'(sel_ok && bus.sel_id == 2'(k));
  end
  for (genvar i = 0; i < NUM_PRODUCTS; i++) begin : g_sold
    assign bus.sold_out[i] = stock[i] == 4'd0;
  end
`else
  assign in_stock = 1'b1;
  assign bus.sold_out = '0;
`endif
endmodule

// File: tb/tb_vending_machine.sv
// tb_vending_machine: directed stimulus checked every cycle against a scheduled-event model
module tb_vending_machine;
  import vending_pkg::*;
  localparam int N = 4096;
  logic clk = 1'b0;
  logic rst = 1'b1;
  vending_if bus();
  vending_machine dut (.clk(clk), .rst(rst), .bus(bus));
  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;
  int cyc = 0;
  int m_credit = 0;
  int avail_from = 0;
  int m_stock [4];
  int e_credit [N];
  int e_disp [N];
  int e_ch [N];
  bit e_rej [N];
  bit e_serr [N];
  int e_sold [N];
  int price [4] = '{10, 15, 25, 30};
`ifdef VENDING_STOCK_EN
  localparam int STOCK0 = 3;
`else
  localparam int STOCK0 = 1000000;
`endif

  task automatic chk(string nm, int act, int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s cycle %0d: got %0d expected %0d", nm, cyc, act, exp);
    end
  endtask

  function automatic int units(coin_t c);
    case (c)
      COIN_5C: return 1;
      COIN_10C: return 2;
      COIN_25C: return 5;
      default: return 20;
    endcase
  endfunction

  initial begin
    for (int i = 0; i < N; i++) begin
      e_credit[i] = 0; e_disp[i] = -1; e_ch[i] = 0; e_rej[i] = 0; e_serr[i] = 0; e_sold[i] = 0;
    end
    for (int p = 0; p < 4; p++) m_stock[p] = STOCK0;
  end

  // model: at each edge, schedule what the outputs must show in later cycles
  always @(posedge clk) begin
    int n, s;
    n = cyc;
    if (rst) begin
      m_credit = 0;
      avail_from = n + 1;
      for (int p = 0; p < 4; p++) m_stock[p] = STOCK0;
      for (int k = 1; k <= 2; k++) begin
        e_credit[n+k] = 0; e_disp[n+k] = -1; e_ch[n+k] = 0; e_rej[n+k] = 0; e_serr[n+k] = 0;
      end
    end else begin
      e_disp[n+1] = -1; e_rej[n+1] = 0; e_serr[n+1] = 0;
      if (n >= avail_from) begin
        if (bus.cancel && m_credit > 0) begin
          e_ch[n+1] = m_credit;
          m_credit = 0;
          avail_from = n + 2;
          e_rej[n+1] = bus.coin_valid;
        end else if (bus.sel_valid) begin
          if (m_credit >= price[bus.sel_id] && m_stock[bus.sel_id] > 0) begin
            e_disp[n+1] = int'(bus.sel_id);
            m_stock[bus.sel_id]--;
            if (m_credit > price[bus.sel_id]) begin
              e_ch[n+2] = m_credit - price[bus.sel_id];
              avail_from = n + 3;
            end else avail_from = n + 2;
            m_credit = 0;
          end else e_serr[n+1] = 1;
          e_rej[n+1] = bus.coin_valid;
        end else if (bus.coin_valid) begin
          if (m_credit + units(bus.coin_type) <= 40) m_credit += units(bus.coin_type);
          else e_rej[n+1] = 1;
        end
      end else e_rej[n+1] = bus.coin_valid;
      e_credit[n+1] = m_credit;
    end
    s = 0;
    for (int p = 0; p < 4; p++) if (m_stock[p] == 0) s |= 1 << p;
    e_sold[n+1] = s;
    cyc = n + 1;
  end

  always @(negedge clk) begin
    if (cyc > 0) begin
      chk("credit", int'(bus.credit), e_credit[cyc]);
      chk("coin_reject", int'(bus.coin_reject), int'(e_rej[cyc]));
      chk("dispense_valid", int'(bus.dispense_valid), int'(e_disp[cyc] >= 0));
      chk("dispense_id", int'(bus.dispense_id), e_disp[cyc] >= 0 ? e_disp[cyc] : 0);
      chk("change_valid", int'(bus.change_valid), int'(e_ch[cyc] > 0));
      chk("change_amount", int'(bus.change_amount), e_ch[cyc]);
      chk("sel_error", int'(bus.sel_error), int'(e_serr[cyc]));
      chk("busy", int'(bus.busy), int'(e_disp[cyc] >= 0 || e_ch[cyc] > 0));
      chk("sold_out", int'(bus.sold_out), e_sold[cyc]);
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
    bus.coin_valid = 0; bus.sel_valid = 0; bus.cancel = 0;
  endtask
  task automatic coin(coin_t c);
    bus.coin_valid = 1; bus.coin_type = c; step();
  endtask
  task automatic sel(int id);
    bus.sel_valid = 1; bus.sel_id = 2'(id); step();
  endtask
  task automatic cancel();
    bus.cancel = 1; step();
  endtask

  initial begin
    bus.coin_valid = 0; bus.coin_type = COIN_5C; bus.sel_valid = 0; bus.sel_id = 0; bus.cancel = 0;
    step(); step();
    rst = 0;
    repeat (3) step();
    chk("lit_reset_credit", int'(bus.credit), 0);
    chk("lit_reset_busy", int'(bus.busy), 0);
    coin(COIN_25C); coin(COIN_25C);
    chk("lit_credit10", int'(bus.credit), 10);
    sel(0);
    chk("lit_disp0", int'(bus.dispense_valid), 1);
    chk("lit_disp0_id", int'(bus.dispense_id), 0);
    step();
    chk("lit_no_change", int'(bus.change_valid), 0);
    step();
    coin(COIN_100C); coin(COIN_5C);
    chk("lit_credit21", int'(bus.credit), 21);
    sel(2);
    chk("lit_sel_error", int'(bus.sel_error), 1);
    chk("lit_credit_kept", int'(bus.credit), 21);
    coin(COIN_25C);
    sel(2);
    chk("lit_disp2_id", int'(bus.dispense_id), 2);
    step();
    chk("lit_change1", int'(bus.change_amount), 1);
    step();
    coin(COIN_100C); coin(COIN_100C); coin(COIN_5C);
    chk("lit_overflow_reject", int'(bus.coin_reject), 1);
    chk("lit_credit40", int'(bus.credit), 40);
    cancel();
    chk("lit_refund40", int'(bus.change_amount), 40);
    chk("lit_refund_credit", int'(bus.credit), 0);
    step();
    coin(COIN_100C);
    bus.coin_valid = 1; bus.coin_type = COIN_5C; bus.sel_valid = 1; bus.sel_id = 0; bus.cancel = 1;
    step();
    chk("lit_tri_refund", int'(bus.change_amount), 20);
    chk("lit_tri_no_disp", int'(bus.dispense_valid), 0);
    chk("lit_tri_reject", int'(bus.coin_reject), 1);
    step();
    coin(COIN_25C); coin(COIN_25C); sel(1); coin(COIN_25C); sel(1);
    coin(COIN_5C);
    chk("lit_vend_coin_reject", int'(bus.coin_reject), 1);
    cancel();
    chk("lit_idle_cancel", int'(bus.change_valid), 0);
    coin(COIN_100C); coin(COIN_25C); sel(0);
    rst = 1;
    step();
    rst = 0;
    chk("lit_abort_change", int'(bus.change_valid), 0);
    step(); step();
    repeat (3) begin
      coin(COIN_100C); sel(1); step(); step();
    end
    coin(COIN_100C); sel(1);
`ifdef VENDING_STOCK_EN
    chk("lit_sold_error", int'(bus.sel_error), 1);
    chk("lit_sold_out1", int'(bus.sold_out[1]), 1);
    chk("lit_sold_credit", int'(bus.credit), 20);
    cancel();
`else
    chk("lit_unlimited_disp", int'(bus.dispense_valid), 1);
    chk("lit_sold_out0", int'(bus.sold_out), 0);
`endif
    repeat (3) step();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
